// File: rtl/matrix_loader.sv
// Collects a row-major stream of signed bytes into a packed 5x5 matrix for the det5 stage.
// Optional MAT_SIZE_SEL_EN adds a size port for NxN frames (N=2..5) with identity padding.
module matrix_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [199:0] matrix,
    output logic         mat_valid,
    input  logic         mat_ready,
    output logic         err
`ifdef MAT_SIZE_SEL_EN
    ,
    input  logic [2:0]   size
`endif
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [7:0]  mem_reg [25];
    logic        in_ready_reg;
    logic        mat_valid_reg;
    logic        err_reg;
    logic [4:0]  slot;
    logic [4:0]  last_idx;
    logic        hs;

    assign hs = in_valid && in_ready_reg;

`ifdef MAT_SIZE_SEL_EN
    logic [2:0]  n_reg;
    logic [2:0]  n_sel;
    logic [2:0]  n_cur;
    logic [2:0]  row_reg;
    logic [2:0]  col_reg;
    logic [24:0] pad_mask;
    logic [24:0] pad_one;

    // Order is latched on the first element; later elements use the held value.
    always_comb begin
        n_sel    = (size >= 3'd2 && size <= 3'd5) ? size : 3'd5;
        n_cur    = (idx_reg == 5'd0) ? n_sel : n_reg;
        last_idx = {2'b00, n_cur} * {2'b00, n_cur} - 5'd1;
        slot     = {2'b00, row_reg} * 5'd5 + {2'b00, col_reg};
    end

    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_pad
            localparam logic [2:0] ROW = 3'(gi / 5);
            localparam logic [2:0] COL = 3'(gi % 5);
            assign pad_mask[gi] = (ROW >= n_cur) || (COL >= n_cur);
            assign pad_one[gi]  = (ROW == COL);
        end
    endgenerate
`else
    assign slot     = idx_reg;
    assign last_idx = 5'd24;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= FILL;
            idx_reg       <= 5'd0;
            in_ready_reg  <= 1'b1;
            mat_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            for (int k = 0; k < 25; k++) mem_reg[k] <= 8'd0;
`ifdef MAT_SIZE_SEL_EN
            n_reg   <= 3'd5;
            row_reg <= 3'd0;
            col_reg <= 3'd0;
`endif
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (hs) begin
                        mem_reg[slot] <= in_data;
`ifdef MAT_SIZE_SEL_EN
                        if (idx_reg == 5'd0) n_reg <= n_sel;
                        if (col_reg == n_cur - 3'd1) begin
                            col_reg <= 3'd0;
                            row_reg <= row_reg + 3'd1;
                        end else begin
                            col_reg <= col_reg + 3'd1;
                        end
`endif
                        if (idx_reg == last_idx && in_last) begin
                            state_reg     <= FULL;
                            in_ready_reg  <= 1'b0;
                            mat_valid_reg <= 1'b1;
                            idx_reg       <= 5'd0;
`ifdef MAT_SIZE_SEL_EN
                            row_reg <= 3'd0;
                            col_reg <= 3'd0;
                            for (int k = 0; k < 25; k++)
                                if (pad_mask[k]) mem_reg[k] <= {7'd0, pad_one[k]};
`endif
                        end else if (idx_reg == last_idx || in_last) begin
                            // Framing error: drop the partial frame, keep stale contents.
                            err_reg <= 1'b1;
                            idx_reg <= 5'd0;
`ifdef MAT_SIZE_SEL_EN
                            row_reg <= 3'd0;
                            col_reg <= 3'd0;
`endif
                        end else begin
                            idx_reg <= idx_reg + 5'd1;
                        end
                    end
                end
                FULL: begin
                    if (mat_ready) begin
                        state_reg     <= FILL;
                        in_ready_reg  <= 1'b1;
                        mat_valid_reg <= 1'b0;
                        idx_reg       <= 5'd0;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_pack
            assign matrix[199 - 8*gi -: 8] = mem_reg[gi];
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign mat_valid = mat_valid_reg;
    assign err       = err_reg;

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is `clk`, and the reset is `rst`, asynchronous and active-low.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  signed matrix element, row-major order.
- in_valid  input  1  in_data is presented.
- in_last  input  1  marks the final element of a frame.
- in_ready  output  1  loader accepts an element.
- matrix  output  200  packed 5x5 signed 8-bit matrix for the det5 stage.
- mat_valid  output  1  matrix is complete and stable.
- mat_ready  input  1  det5 stage has consumed matrix.
- err  output  1  one-cycle pulse on a framing error.
- size  input  3  active matrix order; exists only under REQ-020.

Function
REQ-003 Element k (k = 5*row + col) SHALL be packed at matrix[199-8k -: 8], so a00 occupies [199:192] and a44 occupies [7:0].
REQ-004 An element handshake SHALL occur on a rising clk edge where in_valid = 1 and in_ready = 1; no other edge may change the element index or matrix.
REQ-005 The state machine SHALL have two states:
- FILL: in_ready = 1, mat_valid = 0.
- FULL: in_ready = 0, mat_valid = 1.
REQ-006 In FILL, a 5-bit index (0..24) SHALL select the destination slot, and each handshake SHALL write in_data to that slot and increment the index.
REQ-007 A handshake on index 24 with in_last = 1 SHALL move the block to FULL, so mat_valid is 1 on the cycle after that handshake (latency 1 cycle).
REQ-008 In FULL, matrix SHALL stay stable, and in_data/in_valid SHALL be ignored.
REQ-009 In FULL with mat_ready = 1 at a clk edge, the block SHALL return to FILL with index 0, and mat_valid SHALL be 0 from the next cycle.
REQ-010 If mat_ready is 1 while the block is in FILL, it SHALL have no effect.
REQ-011 A handshake with in_last = 1 on any index below 24 SHALL cause all of the following:
- err is driven 1 for exactly one cycle.
- The partial frame is discarded and the index resets to 0.
- The block stays in FILL.
REQ-012 A handshake on index 24 with in_last = 0 SHALL pulse err for one cycle, reset the index to 0, and stay in FILL; mat_valid does not assert.
REQ-013 Matrix contents SHALL NOT be cleared on a framing error or on a FULL-to-FILL transition; stale slots are overwritten by the next frame.
REQ-014 Gaps in in_valid of any length SHALL NOT alter the index or matrix.
REQ-015 in_data SHALL be stored bit-exact, with no sign extension, saturation or arithmetic.

Reset
REQ-016 While rst = 0, the block SHALL be in FILL with index 0, matrix = 0, mat_valid = 0, err = 0 and in_ready = 1.
REQ-017 Asserting rst mid-frame or while in FULL SHALL asynchronously abort the frame and force the REQ-016 values.
REQ-018 The first handshake after reset SHALL be accepted no earlier than the first rising clk edge on which rst = 1.

Configuration
REQ-019 Without macro MAT_SIZE_SEL_EN, the size port SHALL be absent and the frame length SHALL be fixed at 25 elements.
REQ-020 With MAT_SIZE_SEL_EN defined, the size port and its behaviour SHALL be as follows:
- size (3 bits) exists.
- size is sampled at the index-0 handshake and held for that frame; values outside 2..5 are treated as 5.
- The frame is N*N elements, with the final element at index N*N-1 per REQ-007/011/012.
- Elements fill the top-left NxN block in row-major order.
- On completion, every slot with row or col >= N is written 8'sd1 if row = col, else 8'sd0 (identity padding, so det5 yields the NxN determinant).

Verification
REQ-021 Reset: rst = 0 for 5 cycles with in_valid = 1 -> matrix = 0, mat_valid = 0, in_ready = 1, err = 0; then rst = 1.
REQ-022 Full frame: stream 2,3,4,3,1,6,... (25 elements, in_last on the 25th) -> mat_valid = 1 one cycle later, matrix[199:192] = 8'd2, matrix[191:184] = 8'd3, matrix[7:0] = 25th element.
REQ-023 Backpressure and gaps: in_valid toggled 1/0 every cycle, and mat_ready = 0 for 10 cycles after completion -> matrix unchanged, in_ready = 0 throughout; mat_ready = 1 -> in_ready = 1 on the next cycle.
REQ-024 Framing errors:
- in_last on element 10 -> err pulses once, and the following 25-element frame loads correctly.
- No in_last on element 25 -> err pulses and mat_valid stays 0.
REQ-025 Mid-frame reset: rst = 0 after 12 elements -> state cleared; a following 25-element frame completes normally.
REQ-026 MAT_SIZE_SEL_EN with size = 3 and 9 elements 1..9 -> top-left block = 1..9, a33 = a44 = 1, all other padding slots = 0, mat_valid = 1.
